// File: rtl/hist_pkg.sv
// hist_pkg: shared defaults, FSM encodings and types for hist256_engine.
// No ports; imported by hist_bins and hist256_engine.
package hist_pkg;

    localparam int AW_DEF = 17;
    localparam int WD_DEF = 8;
    localparam int CW_DEF = 17;
    localparam int NPIX_DEF = 65536;
    localparam logic [AW_DEF-1:0] BASE_ADDR_DEF = 17'h10000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef logic [CW_DEF-1:0] bin_cnt_t;

endpackage

// File: rtl/hist_bins.sv
// hist_bins: 2^WD x CW bin array with clear, increment, readout and peak tracking.
// Ports: clk_i, rst_ni (sync), clr_i, inc_i/inc_idx_i, rd_idx_i/rd_cnt_o, peak_idx_o, peak_cnt_o.
module hist_bins
    import hist_pkg::*;
#(
    parameter int WD = WD_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [WD-1:0] inc_idx_i,
    input  logic [WD-1:0] rd_idx_i,
    output logic [CW-1:0] rd_cnt_o,
    output logic [WD-1:0] peak_idx_o,
    output logic [CW-1:0] peak_cnt_o
);

    localparam int NB = 1 << WD;

    logic [CW-1:0] bins_q [NB];
    logic [CW-1:0] bin_d;
    logic [WD-1:0] peak_idx_q, peak_idx_d;
    logic [CW-1:0] peak_cnt_q, peak_cnt_d;

    // Post-increment value of the addressed bin; drives both the bin
    // write-back and the peak compare so equal consecutive pixels chain.
    assign bin_d = bins_q[inc_idx_i] + CW'(1);

    // Ties go to the lower index.
    always_comb begin
        peak_idx_d = peak_idx_q;
        peak_cnt_d = peak_cnt_q;
        if (bin_d > peak_cnt_q ||
            (bin_d == peak_cnt_q && inc_idx_i < peak_idx_q)) begin
            peak_idx_d = inc_idx_i;
            peak_cnt_d = bin_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            for (int i = 0; i < NB; i++) begin
                bins_q[i] <= '0;
            end
            peak_idx_q <= '0;
            peak_cnt_q <= '0;
        end else if (inc_i) begin
            bins_q[inc_idx_i] <= bin_d;
            peak_idx_q <= peak_idx_d;
            peak_cnt_q <= peak_cnt_d;
        end
    end

    assign rd_cnt_o   = bins_q[rd_idx_i];
    assign peak_idx_o = peak_idx_q;
    assign peak_cnt_o = peak_cnt_q;

endmodule

// File: rtl/hist256_engine.sv
// hist256_engine: scans NPIX pixels from BASE_ADDR and builds a 256-bin histogram.
// Ports: clk, reset_n, start/busy/finish, cs/we/addr/din/dout memory, hist_idx/hist_cnt, peak_idx/peak_cnt.
module hist256_engine
    import hist_pkg::*;
#(
    parameter int            AW        = AW_DEF,
    parameter int            WD        = WD_DEF,
    parameter logic [AW-1:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int            NPIX      = NPIX_DEF,
    parameter int            CW        = CW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          busy,
    output logic          finish,
    output logic          cs,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [WD-1:0] din,
    input  logic [WD-1:0] dout,
    input  logic [WD-1:0] hist_idx,
    output logic [CW-1:0] hist_cnt,
    output logic [WD-1:0] peak_idx,
    output logic [CW-1:0] peak_cnt
);

    localparam logic [AW-1:0] LAST_ADDR = BASE_ADDR + AW'(NPIX - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rv_q;
    logic          fin_q;
    logic          clr;

    // The address itself is the issue counter; it stops on the last
    // pixel so it never carries past the end of the image.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // fin_q gates out a start landing in the finish cycle.
                if (start && !fin_q) begin
                    state_d = ST_SCAN;
                    addr_d  = BASE_ADDR;
                    clr     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rv_q    <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rv_q    <= (state_q == ST_SCAN);
            fin_q   <= (state_q == ST_DRAIN);
        end
    end

    assign cs     = (state_q == ST_SCAN);
    assign we     = 1'b0;
    assign din    = '0;
    assign addr   = addr_q;
    assign finish = fin_q;
    assign busy   = (state_q != ST_IDLE) || fin_q;

    hist_bins #(
        .WD(WD),
        .CW(CW)
    ) u_bins (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .clr_i      (clr),
        .inc_i      (rv_q),
        .inc_idx_i  (dout),
        .rd_idx_i   (hist_idx),
        .rd_cnt_o   (hist_cnt),
        .peak_idx_o (peak_idx),
        .peak_cnt_o (peak_cnt)
    );

endmodule
